// File: rtl/bp_pkg.sv
// Shared types and helpers for the IF-stage branch predictor.
package bp_pkg;

  localparam int unsigned BP_XLEN  = 32;
  localparam int unsigned BP_TAG_W = 10;
  localparam int unsigned BP_CNT_W = 2;

  typedef enum logic [1:0] {
    BR   = 2'd0,
    JMP  = 2'd1,
    CALL = 2'd2,
    RET  = 2'd3
  } br_type_t;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
    logic [BP_CNT_W-1:0] cnt;
    br_type_t            br_type;
  } bp_entry_t;

  function automatic int unsigned CNT_MAX(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic int unsigned CNT_WEAK_T(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module bp_ras #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr   <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (push) begin
      r_mem[r_ptr] <= push_data;
      r_ptr        <= r_ptr + PTR_W'(1);
      if (r_count != CNT_W'(DEPTH)) r_count <= r_count + CNT_W'(1);
    end else if (pop && (r_count != '0)) begin
      r_ptr   <= r_ptr - PTR_W'(1);
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign top   = r_mem[r_ptr - PTR_W'(1)];
  assign empty = (r_count == '0);

endmodule

// File: rtl/branch_predictor_param.sv
// Direct-mapped tagged BTB with saturating counters and wrap-around statistics.
// Optional return-address stack enabled by defining BP_RAS_EN.
module branch_predictor_param
  import bp_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ENTRIES   = 64,
  parameter int unsigned TAG_W     = 10,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  br_type_t        id_type,
  input  logic            id_taken,
  input  logic [XLEN-1:0] id_target,
  input  logic            id_pred_taken,
  input  logic [XLEN-1:0] id_pred_target,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(CNT_MAX(CNT_W));
  localparam logic [CNT_W-1:0] C_WEAK = CNT_W'(CNT_WEAK_T(CNT_W));

  if ((ENTRIES != (32'd1 << IDX_W)) || (RAS_DEPTH != (32'd1 << $clog2(RAS_DEPTH))) ||
      (CNT_W < 1)) begin : g_bad_param
    $error("ENTRIES and RAS_DEPTH must be powers of 2 and CNT_W >= 1");
  end

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]  r_target [ENTRIES];
  logic [CNT_W-1:0] r_cnt    [ENTRIES];
  br_type_t         r_type   [ENTRIES];
  logic [31:0]      r_stat_branches;
  logic [31:0]      r_stat_mispred;

  logic [IDX_W-1:0] w_if_idx, w_id_idx;
  logic [TAG_W-1:0] w_if_tag, w_id_tag;
  logic             w_id_hit, w_we, w_mispred, w_use_ras;
  logic [CNT_W-1:0] w_cnt;
  logic [XLEN-1:0]  w_tgt, w_ras_top;
  br_type_t         w_typ;
  logic             w_unused;

  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_if_tag = if_pc[IDX_W+2 +: TAG_W];
  assign w_id_idx = id_pc[IDX_W+1:2];
  assign w_id_tag = id_pc[IDX_W+2 +: TAG_W];
  assign w_id_hit = r_valid[w_id_idx] && (r_tag[w_id_idx] == w_id_tag);
  assign w_unused = ^id_pc;

`ifdef BP_RAS_EN
  logic w_ras_empty;

  bp_ras #(.DEPTH(RAS_DEPTH), .XLEN(XLEN)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (id_valid && (id_type == CALL)),
    .pop       (id_valid && (id_type == RET)),
    .push_data (id_pc + XLEN'(4)),
    .top       (w_ras_top),
    .empty     (w_ras_empty)
  );

  assign w_use_ras = (r_type[w_if_idx] == RET) && !w_ras_empty;
`else
  assign w_use_ras = 1'b0;
  assign w_ras_top = '0;
`endif

  // Zero-latency lookup; a same-cycle update is seen only from the next cycle.
  always_comb begin
    pred_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    pred_taken  = pred_hit && r_cnt[w_if_idx][CNT_W-1];
    pred_target = if_pc + XLEN'(4);
    if (pred_taken) pred_target = w_use_ras ? w_ras_top : r_target[w_if_idx];
  end

  // Next contents of the entry addressed by the resolving branch.
  always_comb begin
    w_we  = 1'b0;
    w_cnt = r_cnt[w_id_idx];
    w_tgt = r_target[w_id_idx];
    w_typ = r_type[w_id_idx];
    if (id_valid) begin
      if (w_id_hit) begin
        w_we = 1'b1;
        if (id_type == BR) begin
          if (id_taken) begin
            if (w_cnt != C_MAX) w_cnt = w_cnt + CNT_W'(1);
            w_tgt = id_target;
          end else if (w_cnt != '0) begin
            w_cnt = w_cnt - CNT_W'(1);
          end
        end else begin
          w_cnt = C_MAX;
          w_tgt = id_target;
          w_typ = id_type;
        end
      end else if (id_taken) begin
        w_we  = 1'b1;
        w_cnt = (id_type == BR) ? C_WEAK : C_MAX;
        w_tgt = id_target;
        w_typ = id_type;
      end
    end
  end

  assign w_mispred = (id_pred_taken != id_taken) ||
                     (id_taken && (id_pred_target != id_target));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= '0;
        r_type[i]   <= BR;
      end
      r_stat_branches <= '0;
      r_stat_mispred  <= '0;
    end else begin
      if (w_we) begin
        r_valid[w_id_idx]  <= 1'b1;
        r_tag[w_id_idx]    <= w_id_tag;
        r_target[w_id_idx] <= w_tgt;
        r_cnt[w_id_idx]    <= w_cnt;
        r_type[w_id_idx]   <= w_typ;
      end
      if (id_valid) begin
        r_stat_branches <= r_stat_branches + 32'd1;
        if (w_mispred) r_stat_mispred <= r_stat_mispred + 32'd1;
      end
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_mispred  = r_stat_mispred;

endmodule

// File: tb/tb_branch_predictor_param.sv
// Self-checking bench for branch_predictor_param (default parameters) with a behavioural model.
module tb_branch_predictor_param;
  import bp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        id_valid;
  logic [31:0] id_pc;
  br_type_t    id_type;
  logic        id_taken;
  logic [31:0] id_target;
  logic        id_pred_taken;
  logic [31:0] id_pred_target;
  logic [31:0] stat_branches, stat_mispred;

  branch_predictor_param dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_type        (id_type),
    .id_taken       (id_taken),
    .id_target      (id_target),
    .id_pred_taken  (id_pred_taken),
    .id_pred_target (id_pred_target),
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: 64 entries, index = (pc/4) mod 64, tag = (pc/256) mod 1024, counter 0..3.
  bit          mv   [64];
  int unsigned mtag [64];
  int unsigned mtgt [64];
  int unsigned mcnt [64];
  int unsigned mtyp [64];
  int unsigned mbr, mmis;
  int unsigned ras [$];

  logic        s_hit, s_taken;
  logic [31:0] s_tgt, s_br, s_mis;

  function automatic void mreset();
    for (int i = 0; i < 64; i++) begin
      mv[i] = 0; mtag[i] = 0; mtgt[i] = 0; mcnt[i] = 0; mtyp[i] = 0;
    end
    mbr = 0; mmis = 0;
    ras.delete();
  endfunction

  function automatic void mpredict(input int unsigned pc, output logic hit, output logic taken,
                                   output logic [31:0] tgt);
    int unsigned idx = (pc / 4) % 64;
    hit   = mv[idx] && (mtag[idx] == (pc / 256) % 1024);
    taken = hit && (mcnt[idx] >= 2);
    tgt   = pc + 4;
    if (taken) begin
      tgt = mtgt[idx];
`ifdef BP_RAS_EN
      if (mtyp[idx] == 3 && ras.size() > 0) tgt = ras[ras.size()-1];
`endif
    end
  endfunction

  function automatic void mupdate(input int unsigned pc, input int unsigned ty, input bit tk,
                                  input int unsigned tg, input bit ptk, input int unsigned ptg);
    int unsigned idx = (pc / 4) % 64;
    int unsigned tag = (pc / 256) % 1024;
    bit hit = mv[idx] && (mtag[idx] == tag);
    if (hit) begin
      if (ty == 0) begin
        if (tk) begin
          mcnt[idx] = (mcnt[idx] < 3) ? mcnt[idx] + 1 : 3;
          mtgt[idx] = tg;
        end else begin
          mcnt[idx] = (mcnt[idx] > 0) ? mcnt[idx] - 1 : 0;
        end
      end else begin
        mcnt[idx] = 3; mtgt[idx] = tg; mtyp[idx] = ty;
      end
    end else if (tk) begin
      mv[idx] = 1; mtag[idx] = tag; mtgt[idx] = tg; mtyp[idx] = ty;
      mcnt[idx] = (ty == 0) ? 2 : 3;
    end
    mbr++;
    if ((ptk != tk) || (tk && ptg != tg)) mmis++;
`ifdef BP_RAS_EN
    if (ty == 2) begin
      ras.push_back(pc + 4);
      if (ras.size() > 8) void'(ras.pop_front());
    end else if (ty == 3 && ras.size() > 0) begin
      void'(ras.pop_back());
    end
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, compare lookup and stats at the falling edge, then advance the model.
  task automatic cyc(input logic [31:0] ipc, input logic v, input logic [31:0] pc,
                     input logic [1:0] ty, input logic tk, input logic [31:0] tg,
                     input logic ptk, input logic [31:0] ptg);
    logic eh, et;
    logic [31:0] eg;
    if_pc = ipc; id_valid = v; id_pc = pc; id_type = br_type_t'(ty);
    id_taken = tk; id_target = tg; id_pred_taken = ptk; id_pred_target = ptg;
    @(negedge clk);
    mpredict(ipc, eh, et, eg);
    s_hit = pred_hit; s_taken = pred_taken; s_tgt = pred_target;
    s_br = stat_branches; s_mis = stat_mispred;
    chk("model_hit", 32'(s_hit), 32'(eh));
    chk("model_taken", 32'(s_taken), 32'(et));
    chk("model_target", s_tgt, eg);
    chk("model_branches", s_br, mbr);
    chk("model_mispred", s_mis, mmis);
    @(posedge clk);
    if (v) mupdate(pc, ty, tk, tg, ptk, ptg);
    #1;
  endtask

  task automatic upd(input logic [31:0] ipc, input logic [31:0] pc, input logic [1:0] ty,
                     input logic tk, input logic [31:0] tg);
    logic h, t;
    logic [31:0] g;
    mpredict(pc, h, t, g);
    cyc(ipc, 1'b1, pc, ty, tk, tg, t, g);
  endtask

  task automatic idle(input logic [31:0] ipc);
    cyc(ipc, 1'b0, $urandom, 2'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_hit"}, 32'(pred_hit), 32'd0);
    chk({tag, "_taken"}, 32'(pred_taken), 32'd0);
    chk({tag, "_target"}, pred_target, if_pc + 32'd4);
    chk({tag, "_branches"}, stat_branches, 32'd0);
    chk({tag, "_mispred"}, stat_mispred, 32'd0);
  endtask

  initial begin
    rst = 1'b1; if_pc = 32'h100; id_valid = 1'b0; id_pc = '0; id_type = BR;
    id_taken = 1'b0; id_target = '0; id_pred_taken = 1'b0; id_pred_target = '0;
    mreset();
    #1 rst = 1'b0;
    #2 reset_check("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // Allocate on a taken BR miss
    idle(32'h100);
    chk("idle_miss_target", s_tgt, 32'h104);
    upd(32'h100, 32'h100, 2'd0, 1'b1, 32'h200);
    idle(32'h100);
    chk("alloc_hit", 32'(s_hit), 32'd1);
    chk("alloc_taken", 32'(s_taken), 32'd1);
    chk("alloc_target", s_tgt, 32'h200);
    chk("alloc_branches", s_br, 32'd1);
    chk("alloc_mispred", s_mis, 32'd1);

    // Hysteresis and saturation
    upd(32'h100, 32'h100, 2'd0, 1'b0, 32'h0);
    upd(32'h100, 32'h100, 2'd0, 1'b0, 32'h0);
    idle(32'h100);
    chk("hyst_cnt0_hit", 32'(s_hit), 32'd1);
    chk("hyst_cnt0_taken", 32'(s_taken), 32'd0);
    upd(32'h100, 32'h100, 2'd0, 1'b1, 32'h200);
    idle(32'h100);
    chk("hyst_cnt1_taken", 32'(s_taken), 32'd0);
    repeat (4) upd(32'h100, 32'h100, 2'd0, 1'b1, 32'h200);
    upd(32'h100, 32'h100, 2'd0, 1'b0, 32'h0);
    idle(32'h100);
    chk("sat_taken", 32'(s_taken), 32'd1);

    // Alias: same index, different tag
    idle(32'h200);
    chk("alias_miss", 32'(s_hit), 32'd0);
    upd(32'h200, 32'h200, 2'd0, 1'b0, 32'h0);
    idle(32'h100);
    chk("alias_keep_hit", 32'(s_hit), 32'd1);
    chk("alias_keep_target", s_tgt, 32'h200);
    upd(32'h200, 32'h200, 2'd0, 1'b1, 32'h300);
    idle(32'h100);
    chk("alias_evict", 32'(s_hit), 32'd0);
    idle(32'h200);
    chk("alias_new_target", s_tgt, 32'h300);

    // Same-cycle lookup and update
    upd(32'h200, 32'h200, 2'd0, 1'b0, 32'h0);
    chk("bypass_old_taken", 32'(s_taken), 32'd1);
    chk("bypass_old_target", s_tgt, 32'h300);
    idle(32'h200);
    chk("bypass_new_taken", 32'(s_taken), 32'd0);
    chk("bypass_new_target", s_tgt, 32'h204);

    // Unconditional jump allocates at full strength
    upd(32'h140, 32'h140, 2'd1, 1'b1, 32'h480);
    idle(32'h140);
    chk("jmp_target", s_tgt, 32'h480);

`ifdef BP_RAS_EN
    upd(32'h80, 32'h80, 2'd3, 1'b1, 32'h999);
    upd(32'h40, 32'h40, 2'd2, 1'b1, 32'h500);
    idle(32'h80);
    chk("ras_ret_target", s_tgt, 32'h44);
    for (int i = 0; i < 9; i++) upd(32'h0, 32'h2004 + 32'(i * 16), 2'd2, 1'b1, 32'h600);
    for (int k = 0; k < 8; k++) begin
      idle(32'h80);
      chk("ras_pop_order", s_tgt, 32'h2008 + 32'((8 - k) * 16));
      upd(32'h0, 32'h80, 2'd3, 1'b1, 32'h999);
    end
`endif

    // Randomized traffic over a small aliasing address set
    for (int n = 0; n < 300; n++) begin
      logic [31:0] pc, ipc;
      pc  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      ipc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      if ($urandom_range(0, 3) == 0) idle(ipc);
      else if ($urandom_range(0, 1) == 0)
        upd(ipc, pc, 2'($urandom), 1'($urandom), 32'h1000 + ($urandom_range(0, 3) << 4));
      else
        cyc(ipc, 1'b1, pc, 2'($urandom), 1'($urandom), 32'h1000 + ($urandom_range(0, 3) << 4),
            1'($urandom), 32'h1000 + ($urandom_range(0, 3) << 4));
    end

    // Mid-run reset
    if_pc = 32'h100; id_valid = 1'b0;
    @(negedge clk); #2 rst = 1'b0;
    #1 reset_check("midreset");
    @(posedge clk); #1 reset_check("midreset_hold");
    rst = 1'b1;
    mreset();
    @(posedge clk); #1;
    idle(32'h100);
    chk("post_reset_hit", 32'(s_hit), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
